count8_period_ctrl: RTL and testbench
=====================================

// Module: count8_period_ctrl
// PURPOSE
//  Upstream controller for the 8-bit ripple up-counter: drives its EN, load and CNT_In inputs
//  and consumes its CNT output to build a programmable-period timer.
//  Samples CNT on clk, compares it against a programmable compare value, pulses load to reload
//  the counter, and publishes each period event on a valid/ready interface.
// PARAMETERS
//  RELOAD_VAL   8'h00  value driven on CNT_In; the counter restarts from it after every reload
//  AUTO_RELOAD  1      1: free-running periodic timer; 0: one-shot, returns to IDLE after first match
// PORTS
//  clk        in   1  single clock; same clock as the counter's bit-0 flop
//  res        in   1  reset, asynchronous, active-low
//  start      in   1  level-sampled; starts the timer from IDLE
//  stop       in   1  level-sampled; forces IDLE from any state
//  cmp_in     in   8  compare value
//  cmp_wr     in   1  write strobe for cmp_in
//  CNT        in   8  counter value, from the counter's CNT output
//  EN         out  1  count enable to the counter
//  load       out  1  async-load request to the counter
//  CNT_In     out  8  load value to the counter; constant RELOAD_VAL
//  evt_valid  out  1  period event available
//  evt_ready  in   1  consumer accepts the event
//  evt_seq    out  8  event sequence number; wraps 255->0
//  ovf        out  1  sticky: an event was lost because evt_valid was held
//  cfg_err    out  1  sticky: a cmp_wr carried cmp_in == RELOAD_VAL
// BEHAVIOUR
//  Reset values (res=0, applied immediately, including mid-operation):
//   state=IDLE; EN=0; load=0; cmp_act=cmp_sh=8'hFF; cnt_q=0; evt_valid=0; evt_seq=0; ovf=0; cfg_err=0.
//  Sampling:
//   - cnt_q <= CNT every clk. The counter's ripple settles within one period, so cnt_q holds the pre-edge value.
//   - No other filtering is applied.
//  FSM states (all outputs registered):
//   IDLE: EN=0, load=0. start & !stop -> LOAD.
//   LOAD: load=1, EN=0, for exactly 1 cycle; the counter is forced to RELOAD_VAL. cmp_act <= cmp_sh. -> ARM.
//   ARM:  load=0, EN=1, compare blanked. -> RUN.
//   RUN:  EN=1. When cnt_q == cmp_act: match.
//         AUTO_RELOAD=1 -> LOAD; AUTO_RELOAD=0 -> LOAD, then IDLE in place of ARM.
//   stop=1 in any state -> IDLE at the next edge. stop wins over start and over a match in the same cycle.
//  Timing:
//   - Period from ARM entry to next ARM entry = cmp_act - RELOAD_VAL + 3 clk (8-bit modular difference).
//   - The match is registered, so LOAD begins 2 edges after CNT first equals cmp_act.
//  Compare write:
//   - In IDLE: cmp_sh and cmp_act are both updated.
//   - In any other state: only cmp_sh is updated; it applies at the next LOAD.
//   - cmp_in == RELOAD_VAL: the write is ignored and cfg_err is set.
//   - cmp_wr in the same cycle as the LOAD copy: the new value takes effect at the following LOAD.
//  Event port:
//   - On match, if !evt_valid or (evt_valid & evt_ready): evt_valid <= 1 and evt_seq <= evt_seq + 1.
//   - Otherwise evt_seq still increments, evt_valid is held and ovf <= 1.
//   - evt_valid & evt_ready with no match: evt_valid <= 0.
//   - evt_seq is stable while evt_valid=1 and not accepted.
//   - ovf and cfg_err are cleared only by reset or by the IDLE->LOAD transition.
// STRUCTURE
//  Shared include count_defs.vh: state encodings (IDLE=2'd0, LOAD=2'd1, ARM=2'd2, RUN=2'd3)
//  and the default RELOAD_VAL.
//  Sub-module count8_evt_reg: the valid/ready event register with overflow flag.
//  The FSM, compare logic and sampling register stay in the top level.
//  Use library flops with async reset for all state.
// TESTING (bench instantiates this block plus the real 8-bit counter)
//  1. RELOAD_VAL=0, cmp_wr 10 in IDLE, start -> evt_valid pulses every 13 clk; evt_seq 1,2,3...; CNT never exceeds 12.
//  2. evt_ready held 0 over two matches -> evt_seq stays 1 while valid; ovf=1; the next accept shows the current seq.
//  3. cmp_wr 20 mid-RUN with cmp_act=10 -> current period stays 13; the next period is 23.
//  4. cmp_wr 0 with RELOAD_VAL=0 -> cfg_err=1, cmp_act unchanged; a later start clears cfg_err.
//  5. start & stop together in IDLE -> stays IDLE, EN=0; stop during LOAD -> IDLE next edge, load=0.
//  6. res low mid-RUN -> EN, load, evt_valid drop immediately; evt_seq=0. AUTO_RELOAD=0 -> exactly one event, then IDLE.

Source files
------------

// File: rtl/count8_period_ctrl_pkg.sv
// Shared definitions for the programmable-period controller: FSM encodings and default values.
// No logic; no latency or backpressure of its own.
package count8_period_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ARM  = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    localparam logic [7:0] RELOAD_VAL_DEF = 8'h00;
    localparam logic [7:0] CMP_RST_VAL    = 8'hFF;

endpackage

// File: rtl/count8_evt_reg.sv
// Period-event register: one-deep valid/ready holding slot, sequence counter, sticky overflow; event visible 1 clk after match.
// Backpressure: a match while the slot is held is dropped (seq still advances) and flags ovf.
module count8_evt_reg (
    input  logic       clk,
    input  logic       res,
    input  logic       match,
    input  logic       clr_ovf,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [7:0] evt_seq,
    output logic       ovf
);

    logic       valid_q, valid_d;
    logic [7:0] seq_q, seq_d;
    logic [7:0] seq_cnt_q, seq_cnt_d;
    logic       ovf_q, ovf_d;

    always_comb begin
        valid_d   = valid_q;
        seq_d     = seq_q;
        seq_cnt_d = seq_cnt_q;
        ovf_d     = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        // The published number only moves when a new event enters the slot,
        // so a held event keeps its own number while the count runs on.
        if (match) begin
            seq_cnt_d = seq_cnt_q + 8'd1;
            if (!valid_q || evt_ready) begin
                valid_d = 1'b1;
                seq_d   = seq_cnt_q + 8'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && evt_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            valid_q   <= 1'b0;
            seq_q     <= 8'h00;
            seq_cnt_q <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            seq_q     <= seq_d;
            seq_cnt_q <= seq_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_seq   = seq_q;
    assign ovf       = ovf_q;

endmodule

// File: rtl/count8_period_ctrl.sv
// Programmable-period timer driving an external 8-bit counter; match registered, LOAD 2 clk after CNT hits cmp_act.
// Backpressure: events never stall the timer; unaccepted events are counted and flagged via ovf.
module count8_period_ctrl
    import count8_period_ctrl_pkg::*;
#(
    parameter logic [7:0] RELOAD_VAL  = RELOAD_VAL_DEF,
    parameter bit         AUTO_RELOAD = 1'b1
) (
    input  logic       clk,
    input  logic       res,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] cmp_in,
    input  logic       cmp_wr,
    input  logic [7:0] CNT,
    output logic       EN,
    output logic       load,
    output logic [7:0] CNT_In,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_seq,
    output logic       ovf,
    output logic       cfg_err
);

    state_e     state_q, state_d;
    logic       en_q, en_d;
    logic       load_q, load_d;
    logic [7:0] cmp_act_q, cmp_act_d;
    logic [7:0] cmp_sh_q, cmp_sh_d;
    logic [7:0] cnt_q;
    logic       cfg_err_q, cfg_err_d;
    logic       from_run_q, from_run_d;
    logic       match;
    logic       start_load;

    always_comb begin
        state_d    = state_q;
        cmp_act_d  = cmp_act_q;
        cmp_sh_d   = cmp_sh_q;
        cfg_err_d  = cfg_err_q;
        from_run_d = from_run_q;
        match      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cmp_act_d = cmp_sh_q;
                state_d   = (!AUTO_RELOAD && from_run_q) ? ST_IDLE : ST_ARM;
            end
            ST_ARM: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == cmp_act_q && !stop) begin
                    match   = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (stop) begin
            state_d = ST_IDLE;
        end

        // Remembers whether this LOAD closes a period, so one-shot mode can retire to IDLE.
        if (state_d == ST_LOAD) begin
            from_run_d = (state_q == ST_RUN);
        end

        start_load = (state_q == ST_IDLE) && (state_d == ST_LOAD);
        if (start_load) begin
            cfg_err_d = 1'b0;
        end

        if (cmp_wr) begin
            if (cmp_in == RELOAD_VAL) begin
                cfg_err_d = 1'b1;
            end else begin
                cmp_sh_d = cmp_in;
                if (state_q == ST_IDLE) begin
                    cmp_act_d = cmp_in;
                end
            end
        end

        en_d   = (state_d == ST_ARM) || (state_d == ST_RUN);
        load_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            load_q     <= 1'b0;
            cmp_act_q  <= CMP_RST_VAL;
            cmp_sh_q   <= CMP_RST_VAL;
            cnt_q      <= 8'h00;
            cfg_err_q  <= 1'b0;
            from_run_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            load_q     <= load_d;
            cmp_act_q  <= cmp_act_d;
            cmp_sh_q   <= cmp_sh_d;
            cnt_q      <= CNT;
            cfg_err_q  <= cfg_err_d;
            from_run_q <= from_run_d;
        end
    end

    count8_evt_reg u_evt (
        .clk       (clk),
        .res       (res),
        .match     (match),
        .clr_ovf   (start_load),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_seq   (evt_seq),
        .ovf       (ovf)
    );

    assign EN      = en_q;
    assign load    = load_q;
    assign CNT_In  = RELOAD_VAL;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_count8_period_ctrl.sv
// Bench for count8_period_ctrl with a behavioural 8-bit counter (async load) behind each instance.
// Instance u_auto is free-running; u_os is one-shot and shares all control inputs.
module tb_count8_period_ctrl;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] cmp_in = 8'h00;
    logic       cmp_wr = 1'b0;
    logic       evt_ready = 1'b1;

    logic [7:0] cnt_a = 8'h00;
    logic       en_a, load_a, vld_a, ovf_a, err_a;
    logic [7:0] cin_a, seq_a;
    logic [7:0] cnt_o = 8'h00;
    logic       en_o, load_o, vld_o, ovf_o, err_o;
    logic [7:0] cin_o, seq_o;

    logic [7:0] cnt_max = 8'h00;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    count8_period_ctrl #(.RELOAD_VAL(8'h00), .AUTO_RELOAD(1'b1)) u_auto (
        .clk(clk), .res(res), .start(start), .stop(stop), .cmp_in(cmp_in), .cmp_wr(cmp_wr),
        .CNT(cnt_a), .EN(en_a), .load(load_a), .CNT_In(cin_a), .evt_valid(vld_a),
        .evt_ready(evt_ready), .evt_seq(seq_a), .ovf(ovf_a), .cfg_err(err_a)
    );

    count8_period_ctrl #(.RELOAD_VAL(8'h00), .AUTO_RELOAD(1'b0)) u_os (
        .clk(clk), .res(res), .start(start), .stop(stop), .cmp_in(cmp_in), .cmp_wr(cmp_wr),
        .CNT(cnt_o), .EN(en_o), .load(load_o), .CNT_In(cin_o), .evt_valid(vld_o),
        .evt_ready(evt_ready), .evt_seq(seq_o), .ovf(ovf_o), .cfg_err(err_o)
    );

    // Counter models: async load overrides, otherwise count on clk when enabled.
    always @(posedge clk or posedge load_a) begin
        if (load_a) cnt_a <= cin_a;
        else if (en_a) cnt_a <= cnt_a + 8'd1;
    end

    always @(posedge clk or posedge load_o) begin
        if (load_o) cnt_o <= cin_o;
        else if (en_o) cnt_o <= cnt_o + 8'd1;
    end

    always @(cnt_a) begin
        if (cnt_a > cnt_max) cnt_max = cnt_a;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        res = 1'b0; start = 1'b0; stop = 1'b0; cmp_wr = 1'b0; cmp_in = 8'h00;
        step(2);
        res = 1'b1;
        step(1);
    endtask

    task automatic write_cmp(input logic [7:0] v);
        cmp_in = v; cmp_wr = 1'b1;
        step(1);
        cmp_wr = 1'b0;
    endtask

    // Leaves the bench at the negedge just after the IDLE->LOAD edge.
    task automatic kick();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b0;
        step(1);
        total++; if (en_a !== 1'b0) begin bad++; $display("FAIL rst_en: got %0b want 0", en_a); end
        total++; if (load_a !== 1'b0) begin bad++; $display("FAIL rst_load: got %0b want 0", load_a); end
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", vld_a); end
        total++; if (seq_a !== 8'd0) begin bad++; $display("FAIL rst_seq: got %0d want 0", seq_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %0b want 0", ovf_a); end
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL rst_cfg_err: got %0b want 0", err_a); end
        total++; if (cin_a !== 8'h00) begin bad++; $display("FAIL rst_cnt_in: got %0h want 0", cin_a); end
        res = 1'b1;
        step(1);
    endtask

    task automatic test_period();
        int n;
        do_reset();
        evt_ready = 1'b1;
        write_cmp(8'd10);
        kick();
        total++; if (load_a !== 1'b1) begin bad++; $display("FAIL per_load0: got %0b want 1", load_a); end
        total++; if (en_a !== 1'b0) begin bad++; $display("FAIL per_en0: got %0b want 0", en_a); end
        step(1);
        total++; if (en_a !== 1'b1 || load_a !== 1'b0) begin bad++; $display("FAIL per_arm: got en=%0b load=%0b want en=1 load=0", en_a, load_a); end
        cnt_max = 8'h00;
        n = 0;
        for (int i = 2; i <= 45; i++) begin
            step(1);
            if (vld_a === 1'b1) begin
                n++;
                total++; if (i != 13 * n) begin bad++; $display("FAIL per_evt%0d_time: got idx %0d want %0d", n, i, 13 * n); end
                total++; if (seq_a !== n[7:0]) begin bad++; $display("FAIL per_evt%0d_seq: got %0d want %0d", n, seq_a, n); end
            end
        end
        total++; if (n != 3) begin bad++; $display("FAIL per_count: got %0d want 3", n); end
        total++; if (cnt_max > 8'd12) begin bad++; $display("FAIL per_cnt_max: got %0d want <=12", cnt_max); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL per_ovf: got %0b want 0", ovf_a); end
    endtask

    task automatic test_overflow();
        do_reset();
        evt_ready = 1'b0;
        write_cmp(8'd10);
        kick();
        step(13);
        total++; if (vld_a !== 1'b1 || seq_a !== 8'd1) begin bad++; $display("FAIL ovf_first: got vld=%0b seq=%0d want vld=1 seq=1", vld_a, seq_a); end
        total++; if (ovf_a !== 1'b0) begin bad++; $display("FAIL ovf_early: got %0b want 0", ovf_a); end
        step(7);
        total++; if (seq_a !== 8'd1) begin bad++; $display("FAIL ovf_seq_hold: got %0d want 1", seq_a); end
        step(6);
        total++; if (vld_a !== 1'b1 || seq_a !== 8'd1) begin bad++; $display("FAIL ovf_second: got vld=%0b seq=%0d want vld=1 seq=1", vld_a, seq_a); end
        total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL ovf_set: got %0b want 1", ovf_a); end
        evt_ready = 1'b1;
        step(1);
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL ovf_accept: got %0b want 0", vld_a); end
        step(12);
        total++; if (vld_a !== 1'b1 || seq_a !== 8'd3) begin bad++; $display("FAIL ovf_third: got vld=%0b seq=%0d want vld=1 seq=3", vld_a, seq_a); end
        total++; if (ovf_a !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %0b want 1", ovf_a); end
    endtask

    task automatic test_cmp_update();
        do_reset();
        evt_ready = 1'b1;
        write_cmp(8'd10);
        kick();
        step(5);
        write_cmp(8'd20);
        step(7);
        total++; if (vld_a !== 1'b1) begin bad++; $display("FAIL upd_evt13: got %0b want 1", vld_a); end
        step(13);
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL upd_no_evt26: got %0b want 0", vld_a); end
        step(9);
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL upd_no_evt35: got %0b want 0", vld_a); end
        step(1);
        total++; if (vld_a !== 1'b1 || seq_a !== 8'd2) begin bad++; $display("FAIL upd_evt36: got vld=%0b seq=%0d want vld=1 seq=2", vld_a, seq_a); end
    endtask

    task automatic test_cfg_err();
        do_reset();
        evt_ready = 1'b1;
        write_cmp(8'd10);
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL cfg_ok_write: got %0b want 0", err_a); end
        write_cmp(8'd0);
        total++; if (err_a !== 1'b1) begin bad++; $display("FAIL cfg_set: got %0b want 1", err_a); end
        step(2);
        total++; if (err_a !== 1'b1) begin bad++; $display("FAIL cfg_sticky: got %0b want 1", err_a); end
        kick();
        total++; if (err_a !== 1'b0) begin bad++; $display("FAIL cfg_clear_on_start: got %0b want 0", err_a); end
        step(13);
        total++; if (vld_a !== 1'b1) begin bad++; $display("FAIL cfg_cmp_kept: got %0b want 1", vld_a); end
    endtask

    task automatic test_start_stop();
        do_reset();
        start = 1'b1; stop = 1'b1;
        step(1);
        total++; if (en_a !== 1'b0 || load_a !== 1'b0) begin bad++; $display("FAIL ss_both: got en=%0b load=%0b want 0 0", en_a, load_a); end
        step(2);
        total++; if (en_a !== 1'b0 || load_a !== 1'b0) begin bad++; $display("FAIL ss_both_hold: got en=%0b load=%0b want 0 0", en_a, load_a); end
        start = 1'b0; stop = 1'b0;
        kick();
        total++; if (load_a !== 1'b1) begin bad++; $display("FAIL ss_load: got %0b want 1", load_a); end
        stop = 1'b1;
        step(1);
        total++; if (load_a !== 1'b0 || en_a !== 1'b0) begin bad++; $display("FAIL ss_stop_load: got load=%0b en=%0b want 0 0", load_a, en_a); end
        stop = 1'b0;
        step(3);
        total++; if (load_a !== 1'b0 || en_a !== 1'b0) begin bad++; $display("FAIL ss_idle_stay: got load=%0b en=%0b want 0 0", load_a, en_a); end
    endtask

    task automatic test_reset_mid_run_and_oneshot();
        int n;
        do_reset();
        evt_ready = 1'b0;
        write_cmp(8'd10);
        kick();
        step(16);
        total++; if (vld_a !== 1'b1 || en_a !== 1'b1) begin bad++; $display("FAIL mid_pre: got vld=%0b en=%0b want 1 1", vld_a, en_a); end
        #2 res = 1'b0;
        #1;
        total++; if (en_a !== 1'b0 || load_a !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl: got en=%0b load=%0b want 0 0", en_a, load_a); end
        total++; if (vld_a !== 1'b0 || seq_a !== 8'd0) begin bad++; $display("FAIL mid_rst_evt: got vld=%0b seq=%0d want 0 0", vld_a, seq_a); end
        step(1);
        do_reset();
        evt_ready = 1'b1;
        write_cmp(8'd10);
        kick();
        step(13);
        total++; if (vld_o !== 1'b1 || seq_o !== 8'd1 || load_o !== 1'b1) begin bad++; $display("FAIL os_evt: got vld=%0b seq=%0d load=%0b want 1 1 1", vld_o, seq_o, load_o); end
        step(1);
        total++; if (load_o !== 1'b0 || en_o !== 1'b0) begin bad++; $display("FAIL os_idle: got load=%0b en=%0b want 0 0", load_o, en_o); end
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (vld_o === 1'b1 || en_o === 1'b1) n++;
        end
        total++; if (n != 0 || seq_o !== 8'd1) begin bad++; $display("FAIL os_single: got active=%0d seq=%0d want 0 1", n, seq_o); end
        total++; if (seq_a !== 8'd3) begin bad++; $display("FAIL auto_alongside: got seq=%0d want 3", seq_a); end
    endtask

    initial begin
        test_reset();
        test_period();
        test_overflow();
        test_cmp_update();
        test_cfg_err();
        test_start_stop();
        test_reset_mid_run_and_oneshot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
